// File: rtl/nts_api_arbiter_if.sv
// Signal bundle between the two API requesters, the arbiter and the downstream
// address-decode pipeline. The arbiter connects through the slave modport.
interface nts_api_arbiter_if;
   logic        i_req0;
   logic        i_we0;
   logic [11:0] i_addr0;
   logic [31:0] i_wdata0;
   logic        o_ack0;
   logic        o_err0;
   logic [31:0] o_rdata0;

   logic        i_req1;
   logic        i_we1;
   logic [11:0] i_addr1;
   logic [31:0] i_wdata1;
   logic        o_ack1;
   logic        o_err1;
   logic [31:0] o_rdata1;

   logic        o_api_cs;
   logic        o_api_we;
   logic [11:0] o_api_address;
   logic [31:0] o_api_write_data;
   logic [31:0] i_api_read_data;
   logic        i_api_read_data_valid;
   logic        i_api_busy;

   logic        o_grant;

   modport slave (
      input  i_req0, i_we0, i_addr0, i_wdata0,
      input  i_req1, i_we1, i_addr1, i_wdata1,
      input  i_api_read_data, i_api_read_data_valid, i_api_busy,
      output o_ack0, o_err0, o_rdata0,
      output o_ack1, o_err1, o_rdata1,
      output o_api_cs, o_api_we, o_api_address, o_api_write_data,
      output o_grant
   );

   modport master (
      output i_req0, i_we0, i_addr0, i_wdata0,
      output i_req1, i_we1, i_addr1, i_wdata1,
      output i_api_read_data, i_api_read_data_valid, i_api_busy,
      input  o_ack0, o_err0, o_rdata0,
      input  o_ack1, o_err1, o_rdata1,
      input  o_api_cs, o_api_we, o_api_address, o_api_write_data,
      input  o_grant
   );
endinterface

// File: rtl/nts_api_arbiter.sv
// Round-robin arbiter sharing the NTS 12-bit API bus between the host bridge
// (requester 0) and the config sequencer (requester 1), with a response timeout.
module nts_api_arbiter #(
   parameter logic [7:0] TIMEOUT_CYCLES = 8'd16
) (
   input  logic             i_clk,
   input  logic             i_areset_n,
   nts_api_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t      r_state;
   logic [7:0]  r_timer;
   logic        r_last_grant;
   logic        r_grant;
   logic        r_ack0;
   logic        r_ack1;
   logic        r_err0;
   logic        r_err1;
   logic [31:0] r_rdata0;
   logic [31:0] r_rdata1;
   logic        r_api_cs;
   logic        r_api_we;
   logic [11:0] r_api_address;
   logic [31:0] r_api_write_data;

   logic        w_any_req;
   logic        w_next_grant;
   logic        w_valid;
   logic        w_timeout;
   logic [31:0] w_resp_data;

   assign w_any_req    = bus.i_req0 | bus.i_req1;
   // Contention goes to whoever did not win last; a lone requester always wins.
   assign w_next_grant = (bus.i_req0 & bus.i_req1) ? ~r_last_grant : bus.i_req1;
   assign w_valid      = bus.i_api_read_data_valid;
   assign w_timeout    = (r_timer == (TIMEOUT_CYCLES - 8'd1));
   assign w_resp_data  = w_valid ? bus.i_api_read_data : 32'd0;

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         r_state          <= IDLE;
         r_timer          <= 8'd0;
         r_last_grant     <= 1'b1;
         r_grant          <= 1'b1;
         r_ack0           <= 1'b0;
         r_ack1           <= 1'b0;
         r_err0           <= 1'b0;
         r_err1           <= 1'b0;
         r_rdata0         <= 32'd0;
         r_rdata1         <= 32'd0;
         r_api_cs         <= 1'b0;
         r_api_we         <= 1'b0;
         r_api_address    <= 12'd0;
         r_api_write_data <= 32'd0;
      end else begin
         // NOTE: one-cycle pulses are defaulted low here and only raised by the
         // state that owns them, so no state can leave a pulse stuck high.
         r_api_cs <= 1'b0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_err0   <= 1'b0;
         r_err1   <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_any_req && !bus.i_api_busy) begin
                  r_grant          <= w_next_grant;
                  r_api_we         <= w_next_grant ? bus.i_we1    : bus.i_we0;
                  r_api_address    <= w_next_grant ? bus.i_addr1  : bus.i_addr0;
                  r_api_write_data <= w_next_grant ? bus.i_wdata1 : bus.i_wdata0;
                  r_api_cs         <= 1'b1;
                  r_state          <= ISSUE;
               end
            end

            ISSUE: begin
               r_timer <= 8'd0;
               r_state <= WAIT;
            end

            WAIT: begin
               r_timer <= r_timer + 8'd1;
               // A response arriving on the timeout cycle still counts as success.
               if (w_valid || w_timeout) begin
                  if (r_grant) begin
                     r_rdata1 <= w_resp_data;
                     r_err1   <= ~w_valid;
                     r_ack1   <= 1'b1;
                  end else begin
                     r_rdata0 <= w_resp_data;
                     r_err0   <= ~w_valid;
                     r_ack0   <= 1'b1;
                  end
                  r_state <= DONE;
               end
            end

            DONE: begin
               r_last_grant <= r_grant;
               r_state      <= IDLE;
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.o_ack0           = r_ack0;
   assign bus.o_err0           = r_err0;
   assign bus.o_rdata0         = r_rdata0;
   assign bus.o_ack1           = r_ack1;
   assign bus.o_err1           = r_err1;
   assign bus.o_rdata1         = r_rdata1;
   assign bus.o_api_cs         = r_api_cs;
   assign bus.o_api_we         = r_api_we;
   assign bus.o_api_address    = r_api_address;
   assign bus.o_api_write_data = r_api_write_data;
   assign bus.o_grant          = r_grant;

endmodule

// File: tb/tb_nts_api_arbiter.sv
// Self-checking bench for nts_api_arbiter: requester drivers feed a scoreboard,
// a downstream responder model answers cs pulses, a monitor checks every ack.
module tb_nts_api_arbiter;

   localparam int TIMEOUT = 16;

   typedef struct {
      logic        idx;
      logic        we;
      logic [11:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          start;
   } txn_t;

   typedef struct {
      logic idx;
      int   cyc;
   } ack_rec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   nts_api_arbiter_if bus ();

   nts_api_arbiter #(.TIMEOUT_CYCLES(8'd16)) dut (
      .i_clk      (clk),
      .i_areset_n (rst_n),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   int cs_count = 0;
   int ack_count = 0;

   txn_t     job_q [2][$];
   txn_t     exp_q [2][$];
   ack_rec_t ack_log[$];

   int          ds_lat = 4;
   logic        ds_valid;
   logic [31:0] ds_data;
   logic [31:0] ds_pend_data;
   logic        man_valid;
   logic [31:0] man_data;

   assign bus.i_api_read_data_valid = ds_valid | man_valid;
   assign bus.i_api_read_data       = man_valid ? man_data : ds_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name, input string msg);
      n_checks++;
      n_errors++;
      $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
   endtask

   // Downstream read data: writes return 0, reads a pattern keyed on address.
   function automatic logic [31:0] ds_model(input logic [11:0] a, input logic we);
      if (we) return 32'd0;
      if (a == 12'h012) return 32'hCAFEF00D;
      return {20'hA5C3E, a};
   endfunction

   task automatic drive_req(input int idx, input logic r, input txn_t t);
      if (idx == 0) begin
         bus.i_req0 = r; bus.i_we0 = t.we; bus.i_addr0 = t.addr; bus.i_wdata0 = t.wdata;
      end else begin
         bus.i_req1 = r; bus.i_we1 = t.we; bus.i_addr1 = t.addr; bus.i_wdata1 = t.wdata;
      end
   endtask

   function automatic logic ack_of(input int idx);
      return (idx == 0) ? bus.o_ack0 : bus.o_ack1;
   endfunction

   // One requester: presents queued jobs, holds req until its ack, drops on reset.
   task automatic requester(input int idx);
      txn_t cur;
      logic active = 1'b0;
      cur = '{1'b0, 1'b0, 12'h0, 32'h0, 0, 32'h0, 1'b0, 0, 0};
      drive_req(idx, 1'b0, cur);
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            active = 1'b0;
            drive_req(idx, 1'b0, cur);
            exp_q[idx].delete();
         end else begin
            if (active && ack_of(idx)) begin
               active = 1'b0;
               drive_req(idx, 1'b0, cur);
            end
            if (!active && job_q[idx].size() > 0) begin
               cur = job_q[idx].pop_front();
               cur.start = cyc;
               exp_q[idx].push_back(cur);
               drive_req(idx, 1'b1, cur);
               active = 1'b1;
            end
         end
      end
   endtask

   initial requester(0);
   initial requester(1);

   // Downstream: answers each cs pulse ds_lat cycles later (never when ds_lat is 0).
   initial begin : responder
      int pend;
      pend = 0;
      ds_valid = 1'b0;
      ds_data = 32'd0;
      ds_pend_data = 32'd0;
      forever begin
         @(negedge clk);
         ds_valid = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               ds_valid = 1'b1;
               ds_data  = ds_pend_data;
            end
         end
         if (bus.o_api_cs && ds_lat > 0) begin
            pend = ds_lat;
            ds_pend_data = ds_model(bus.o_api_address, bus.o_api_we);
         end
      end
   end

   task automatic handle_ack(input int idx);
      txn_t t;
      ack_count++;
      ack_log.push_back('{idx[0], cyc});
      if (exp_q[idx].size() == 0) begin
         fail("unexpected_ack", $sformatf("ack%0d with nothing outstanding", idx));
      end else begin
         t = exp_q[idx].pop_front();
         check($sformatf("ack%0d_rdata_%h", idx, t.addr), (idx == 0) ? bus.o_rdata0 : bus.o_rdata1, t.exp_rdata);
         check($sformatf("ack%0d_err_%h", idx, t.addr), (idx == 0) ? bus.o_err0 : bus.o_err1, t.exp_err);
         check($sformatf("ack%0d_grant", idx), bus.o_grant, idx);
         if (t.exp_lat > 0)
            check($sformatf("ack%0d_latency_%h", idx, t.addr), cyc - t.start, t.exp_lat);
      end
   endtask

   initial begin : monitor
      logic prev_cs, prev_ack0, prev_ack1;
      txn_t t;
      prev_cs = 1'b0; prev_ack0 = 1'b0; prev_ack1 = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.o_api_cs) begin
               cs_count++;
               check("cs_single_cycle", prev_cs, 1'b0);
               if (exp_q[bus.o_grant].size() == 0) begin
                  fail("cs_no_request", $sformatf("cs for grant %0d with no request", bus.o_grant));
               end else begin
                  t = exp_q[bus.o_grant][0];
                  check("cs_address", bus.o_api_address, t.addr);
                  check("cs_we", bus.o_api_we, t.we);
                  check("cs_write_data", bus.o_api_write_data, t.wdata);
               end
            end
            if (bus.o_ack0 && bus.o_ack1) fail("ack_exclusive", "both acks high");
            if (bus.o_ack0) begin
               check("ack0_single_cycle", prev_ack0, 1'b0);
               handle_ack(0);
            end
            if (bus.o_ack1) begin
               check("ack1_single_cycle", prev_ack1, 1'b0);
               handle_ack(1);
            end
         end
         prev_cs = bus.o_api_cs; prev_ack0 = bus.o_ack0; prev_ack1 = bus.o_ack1;
      end
   end

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while ((job_q[0].size() + job_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0
             && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) fail(name, "transactions did not drain within budget");
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_pulses"}, {26'd0, bus.o_ack0, bus.o_ack1, bus.o_err0, bus.o_err1,
                                bus.o_api_cs, bus.o_api_we}, 32'd0);
      check({name, "_rdata0"}, bus.o_rdata0, 32'd0);
      check({name, "_rdata1"}, bus.o_rdata1, 32'd0);
      check({name, "_address"}, bus.o_api_address, 32'd0);
      check({name, "_write_data"}, bus.o_api_write_data, 32'd0);
      check({name, "_grant"}, bus.o_grant, 32'd1);
   endtask

   txn_t tbl[7];
   int   cs_before;
   int   ack_before;
   int   exp_order[4];

   initial begin : main
      txn_t j;
      bit   seen;
      bus.i_api_busy = 1'b0;
      man_valid = 1'b0;
      man_data  = 32'd0;

      // idx, we, addr, wdata, downstream latency, rdata, err, cycles req->ack, start
      tbl[0] = '{1'b0, 1'b0, 12'h012, 32'h0000_0000,  4, 32'hCAFEF00D, 1'b0,  6, 0};
      tbl[1] = '{1'b1, 1'b1, 12'h085, 32'h1234_5678,  4, 32'h0000_0000, 1'b0,  6, 0};
      tbl[2] = '{1'b1, 1'b0, 12'h3FF, 32'h0000_0000,  1, 32'hA5C3E3FF, 1'b0,  3, 0};
      tbl[3] = '{1'b0, 1'b1, 12'h000, 32'hFFFF_FFFF,  7, 32'h0000_0000, 1'b0,  9, 0};
      tbl[4] = '{1'b1, 1'b0, 12'h7A5, 32'h0000_0000, 16, 32'hA5C3E7A5, 1'b0, 18, 0};
      tbl[5] = '{1'b0, 1'b0, 12'h800, 32'h0000_0000, 17, 32'h0000_0000, 1'b1, 18, 0};
      tbl[6] = '{1'b0, 1'b0, 12'h012, 32'h0000_0000,  0, 32'h0000_0000, 1'b1, 18, 0};

      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         ds_lat = tbl[i].lat;
         job_q[tbl[i].idx].push_back(tbl[i]);
         wait_idle($sformatf("table_%0d_drain", i), 100);
      end

      // Late valid while the downstream reports busy: no issue, no ack, until busy drops.
      bus.i_api_busy = 1'b1;
      ds_lat = 4;
      cs_before = cs_count;
      ack_before = ack_count;
      job_q[1].push_back('{1'b1, 1'b0, 12'h2C4, 32'h0, 4, 32'hA5C3E2C4, 1'b0, 0, 0});
      repeat (3) @(negedge clk);
      man_data  = 32'hDEAD_BEEF;
      man_valid = 1'b1;
      @(negedge clk);
      man_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("busy_blocks_cs", cs_count, cs_before);
      check("stray_valid_no_ack", ack_count, ack_before);
      bus.i_api_busy = 1'b0;
      wait_idle("busy_release_drain", 60);
      check("busy_release_one_cs", cs_count, cs_before + 1);

      // Reset pulsed in the third WAIT cycle; the downstream answer arrives afterwards.
      ds_lat = 5;
      cs_before = cs_count;
      job_q[0].push_back('{1'b0, 1'b0, 12'h155, 32'h0, 5, 32'hA5C3E155, 1'b0, 0, 0});
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         seen = bus.o_api_cs;
      end
      if (!seen) fail("reset_txn_cs", "no cs within 20 cycles");
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_wait_reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ack_before = ack_count;
      repeat (8) @(negedge clk);
      check("late_valid_no_ack", ack_count, ack_before);
      check("late_valid_no_cs", cs_count, cs_before + 1);

      // Contention from reset: both hold two transactions each.
      ds_lat = 4;
      ack_log.delete();
      job_q[0].push_back('{1'b0, 1'b0, 12'h101, 32'h0,         4, 32'hA5C3E101, 1'b0, 6, 0});
      job_q[0].push_back('{1'b0, 1'b0, 12'h102, 32'h0,         4, 32'hA5C3E102, 1'b0, 0, 0});
      job_q[1].push_back('{1'b1, 1'b1, 12'h201, 32'h0BAD_F00D, 4, 32'h0000_0000, 1'b0, 0, 0});
      job_q[1].push_back('{1'b1, 1'b0, 12'h202, 32'h0,         4, 32'hA5C3E202, 1'b0, 0, 0});
      wait_idle("contention_drain", 120);
      exp_order = '{0, 1, 0, 1};
      check("contention_ack_count", ack_log.size(), 4);
      for (int k = 0; k < 4 && k < ack_log.size(); k++) begin
         check($sformatf("contention_order_%0d", k), ack_log[k].idx, exp_order[k]);
         if (k > 0)
            check($sformatf("contention_spacing_%0d", k), ack_log[k].cyc - ack_log[k-1].cyc, 7);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete (checks %0d, errors %0d)", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule
